// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 word bridge, ddr3_ctrl and test harnesses:
// bus widths, bridge FSM encoding and address slicing helpers.
package ddr3_pkg;

  localparam int LINE_W = 256;            // line width, equals ddr3_ctrl data width
  localparam int WORD_W = 32;             // upstream word width
  localparam int OFFS_W = 5;              // log2(line bytes); LINE_W == 8 << OFFS_W
  localparam int ADDR_W = 32;
  localparam int TAG_W  = ADDR_W - OFFS_W;
  localparam int IDX_W  = OFFS_W - 2;
  localparam int WORDS  = LINE_W / WORD_W;

  // Bridge FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Upstream byte address split into line tag, word index and byte offset
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       byte_off;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return addr_t'(addr);
  endfunction

  // Line byte address for a tag (offset bits forced to zero)
  function automatic logic [ADDR_W-1:0] line_base(input logic [TAG_W-1:0] tag);
    return {tag, {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ddr3_line_buf.sv
// Single-line buffer: holds one line with its tag, valid and dirty flags.
// Word-select read port and word-merge write port share one word index.
module ddr3_line_buf
  import ddr3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  sel_idx,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              clean_en,
  output logic [WORD_W-1:0] rd_word,
  output logic [LINE_W-1:0] cur_line,
  output logic [TAG_W-1:0]  cur_tag,
  output logic              cur_valid,
  output logic              cur_dirty
);

  // Word k of the line sits at bits [32k+31:32k]
  always_comb begin
    rd_word = cur_line[int'(sel_idx)*WORD_W +: WORD_W];
  end

  // Line storage: a fill replaces the whole line clean, a word write marks it dirty
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_valid <= 1'b0;
      cur_dirty <= 1'b0;
      cur_tag   <= {TAG_W{1'b0}};
      cur_line  <= {LINE_W{1'b0}};
    end else if (fill_en) begin
      cur_line  <= fill_data;
      cur_tag   <= fill_tag;
      cur_valid <= 1'b1;
      cur_dirty <= 1'b0;
    end else if (wr_en) begin
      cur_line[int'(sel_idx)*WORD_W +: WORD_W] <= wr_data;
      cur_dirty <= 1'b1;
    end else if (clean_en) begin
      cur_dirty <= 1'b0;
    end else begin
      cur_dirty <= cur_dirty;
    end
  end

endmodule

// File: rtl/ddr3_word_bridge.sv
// Word-bus to DDR3 line-bus bridge. One write-back, write-allocate line
// buffer; hits complete in one cycle, misses write back a dirty line (if
// any) and then fill before servicing the latched request.
module ddr3_word_bridge
  import ddr3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  input  logic              we_i,
  input  logic              rd_i,
  output logic              ack_o,
  output logic [ADDR_W-1:0] line_addr_o,
  output logic [LINE_W-1:0] line_data_o,
  input  logic [LINE_W-1:0] line_data_i,
  output logic              line_we_o,
  output logic              line_rd_o,
  input  logic              line_ack_i
);

  logic [1:0]        state;
  addr_t             req_in;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req_we;
  logic [WORD_W-1:0] req_data;
  logic              req_live;
  logic              accept;
  logic              hit;
  logic              unused_byte_off;

  logic [IDX_W-1:0]  sel_idx;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              fill_en;
  logic              clean_en;
  logic [WORD_W-1:0] rd_word;
  logic [LINE_W-1:0] cur_line;
  logic [TAG_W-1:0]  cur_tag;
  logic              cur_valid;
  logic              cur_dirty;

  assign req_in          = split_addr(addr_i);
  assign unused_byte_off = ^req_in.byte_off;
  assign req_live        = we_i | rd_i;
  // The ack cycle still sees the finished request held high; skip it
  assign accept          = (state == ST_IDLE) && req_live && !ack_o;
  assign hit             = cur_valid && (cur_tag == req_in.tag);

  ddr3_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .sel_idx   (sel_idx),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_data (line_data_i),
    .clean_en  (clean_en),
    .rd_word   (rd_word),
    .cur_line  (cur_line),
    .cur_tag   (cur_tag),
    .cur_valid (cur_valid),
    .cur_dirty (cur_dirty)
  );

  // Buffer port control: live request in IDLE, latched request in RESP
  always_comb begin
    sel_idx  = req_in.idx;
    wr_data  = data_i;
    wr_en    = 1'b0;
    fill_en  = 1'b0;
    clean_en = 1'b0;
    case (state)
      ST_IDLE: wr_en = accept && hit && we_i;
      ST_WB:   clean_en = line_ack_i;
      ST_FILL: fill_en = line_ack_i && line_rd_o;
      ST_RESP: begin
        sel_idx = req_idx;
        wr_data = req_data;
        wr_en   = req_live && req_we;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Bridge FSM with registered upstream and downstream handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ack_o       <= 1'b0;
      data_o      <= {WORD_W{1'b0}};
      line_we_o   <= 1'b0;
      line_rd_o   <= 1'b0;
      line_addr_o <= {ADDR_W{1'b0}};
      line_data_o <= {LINE_W{1'b0}};
      req_tag     <= {TAG_W{1'b0}};
      req_idx     <= {IDX_W{1'b0}};
      req_we      <= 1'b0;
      req_data    <= {WORD_W{1'b0}};
    end else begin
      ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_tag  <= req_in.tag;
            req_idx  <= req_in.idx;
            req_we   <= we_i;          // write wins when both are high
            req_data <= data_i;
            if (hit) begin
              ack_o <= 1'b1;
              if (!we_i) begin
                data_o <= rd_word;
              end else begin
                data_o <= data_o;
              end
            end else if (cur_valid && cur_dirty) begin
              line_addr_o <= line_base(cur_tag);
              line_data_o <= cur_line;
              line_we_o   <= 1'b1;
              state       <= ST_WB;
            end else begin
              line_addr_o <= line_base(req_in.tag);
              line_rd_o   <= 1'b1;
              state       <= ST_FILL;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (line_ack_i) begin
            line_we_o   <= 1'b0;
            line_addr_o <= line_base(req_tag);
            state       <= ST_FILL;
          end else begin
            line_we_o <= 1'b1;
          end
        end
        ST_FILL: begin
          // After a writeback the read starts one cycle late, so an ack
          // only counts while the read is actually outstanding
          if (line_ack_i && line_rd_o) begin
            line_rd_o <= 1'b0;
            state     <= ST_RESP;
          end else begin
            line_rd_o <= 1'b1;
          end
        end
        ST_RESP: begin
          // A request withdrawn mid-miss is dropped silently
          if (req_live) begin
            ack_o <= 1'b1;
            if (!req_we) begin
              data_o <= rd_word;
            end else begin
              data_o <= data_o;
            end
          end else begin
            ack_o <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: begin
          line_we_o <= 1'b0;
          line_rd_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_word_bridge.sv
// Directed bench for ddr3_word_bridge with a fixed-latency line memory model.
module tb_ddr3_word_bridge;
  import ddr3_pkg::*;

  localparam int LAT = 3;   // cycles a downstream request is held before its ack

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       addr_i, data_i, data_o;
  logic              we_i, rd_i, ack_o;
  logic [31:0]       line_addr_o;
  logic [255:0]      line_data_o, line_data_i;
  logic              line_we_o, line_rd_o, line_ack_i;

  ddr3_word_bridge dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .line_addr_o(line_addr_o),
    .line_data_o(line_data_o), .line_data_i(line_data_i), .line_we_o(line_we_o),
    .line_rd_o(line_rd_o), .line_ack_i(line_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int              busy = 0;
  int              n_rd = 0;
  int              n_wr = 0;
  logic [31:0]     last_rd_addr = 32'h0;
  logic [31:0]     last_wr_addr = 32'h0;
  logic [255:0]    last_wr_line = 256'h0;
  logic [255:0]    mem [logic [31:0]];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Untouched lines: word k = A5A5_0000 + (addr - 0x100) + 4k
  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'hA5A5_0000 + (a - 32'h100) + 32'(4*k);
    return p;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  // One clock; sample after the edge, then drive the memory model for this cycle
  task automatic step();
    @(posedge clk);
    #1;
    chk("excl_we_rd", {255'b0, line_we_o & line_rd_o}, 256'b0);
    line_ack_i = 1'b0;
    if (line_rd_o || line_we_o) begin
      busy++;
      if (busy == LAT) begin
        busy = 0;
        line_ack_i = 1'b1;
        if (line_rd_o) begin
          n_rd++;
          last_rd_addr = line_addr_o;
          line_data_i  = mem_line(line_addr_o);
        end else begin
          n_wr++;
          last_wr_addr = line_addr_o;
          last_wr_line = line_data_o;
          mem[line_addr_o] = line_data_o;
        end
      end
    end else begin
      busy = 0;
    end
  endtask

  // Master holds the request through the ack cycle, as a real master would
  task automatic do_req(input logic we, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata);
    we_i = we; rd_i = rd; addr_i = a; data_i = d;
    lat = -1;
    rdata = 32'h0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      step();
      if (ack_o) lat = c;
    end
    if (lat < 0) begin
      chk("ack_timeout", {255'b0, ack_o}, 256'd1);
    end else begin
      rdata = data_o;
      step();
      chk("single_ack", {255'b0, ack_o}, 256'd0);
    end
    we_i = 1'b0; rd_i = 1'b0;
  endtask

  typedef struct {
    logic        we, rd;
    logic [31:0] addr, wdata;
    int          lat;
    logic        chk_data;
    logic [31:0] exp_data;
    int          nrd, nwr;
    logic [31:0] rd_addr, wb_addr;
    int          wb_idx;
    logic [31:0] wb_word;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, r0, w0, acks;
    logic [31:0] rdata;

    tbl[0] = '{1'b0, 1'b1, 32'h100,  32'h0,         5, 1'b1, 32'hA5A5_0000, 1, 0, 32'h100,  32'h0,   0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h104,  32'h1234_5678, 1, 1'b0, 32'h0,         0, 0, 32'h0,    32'h0,   0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h104,  32'h0,         1, 1'b1, 32'h1234_5678, 0, 0, 32'h0,    32'h0,   0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h2000, 32'h0,         9, 1'b1, 32'hA5A5_1F00, 1, 1, 32'h2000, 32'h100, 1, 32'h1234_5678};
    tbl[4] = '{1'b1, 1'b1, 32'h108,  32'hDEAD_BEEF, 5, 1'b0, 32'h0,         1, 0, 32'h100,  32'h0,   0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 32'h108,  32'h0,         1, 1'b1, 32'hDEAD_BEEF, 0, 0, 32'h0,    32'h0,   0, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 32'h104,  32'h0,         1, 1'b1, 32'h1234_5678, 0, 0, 32'h0,    32'h0,   0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 32'h100,  32'h0,         1, 1'b1, 32'hA5A5_0000, 0, 0, 32'h0,    32'h0,   0, 32'h0};

    rst = 1'b1; we_i = 1'b0; rd_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    line_ack_i = 1'b0; line_data_i = 256'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_ack",   {255'b0, ack_o},     256'd0);
    chk("rst_we",    {255'b0, line_we_o}, 256'd0);
    chk("rst_rd",    {255'b0, line_rd_o}, 256'd0);
    chk("rst_data",  data_o,              256'd0);
    chk("rst_laddr", line_addr_o,         256'd0);

    // Table-driven main sequence
    for (int i = 0; i < 8; i++) begin
      r0 = n_rd; w0 = n_wr;
      do_req(tbl[i].we, tbl[i].rd, tbl[i].addr, tbl[i].wdata, lat, rdata);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      if (tbl[i].chk_data) chk($sformatf("v%0d_data", i), rdata, tbl[i].exp_data);
      chk($sformatf("v%0d_nrd", i), n_rd - r0, tbl[i].nrd);
      chk($sformatf("v%0d_nwr", i), n_wr - w0, tbl[i].nwr);
      if (tbl[i].nrd > 0) chk($sformatf("v%0d_rd_addr", i), last_rd_addr, tbl[i].rd_addr);
      if (tbl[i].nwr > 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wr_addr, tbl[i].wb_addr);
        chk($sformatf("v%0d_wb_word", i), last_wr_line[tbl[i].wb_idx*32 +: 32], tbl[i].wb_word);
      end
    end

    // Reset while a fill is outstanding (dirty line 0x100 is written back first)
    we_i = 1'b0; rd_i = 1'b1; addr_i = 32'h3000;
    for (int c = 0; c < 30 && !line_rd_o; c++) step();
    chk("fill_seen", {255'b0, line_rd_o}, 256'd1);
    chk("fill_addr", line_addr_o, 256'h3000);
    rst = 1'b1; rd_i = 1'b0;
    step();
    rst = 1'b0;
    chk("fillrst_rd",   {255'b0, line_rd_o}, 256'd0);
    chk("fillrst_ack",  {255'b0, ack_o},     256'd0);
    chk("fillrst_we",   {255'b0, line_we_o}, 256'd0);
    chk("fillrst_data", data_o,              256'd0);
    r0 = n_rd; w0 = n_wr;
    do_req(1'b0, 1'b1, 32'h108, 32'h0, lat, rdata);
    chk("postrst_lat",  lat, 5);
    chk("postrst_data", rdata, 32'hDEAD_BEEF);
    chk("postrst_nrd",  n_rd - r0, 1);
    chk("postrst_nwr",  n_wr - w0, 0);

    // Back-to-back write/read with the counter as data
    r0 = n_rd; w0 = n_wr;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 1'b0, 32'h100 + 32'(4*i), 32'(i), lat, rdata);
      chk($sformatf("b2b%0d_wlat", i), lat, 1);
      do_req(1'b0, 1'b1, 32'h100 + 32'(4*i), 32'h0, lat, rdata);
      chk($sformatf("b2b%0d_rlat", i), lat, 1);
      chk($sformatf("b2b%0d_data", i), rdata, 32'(i));
    end
    chk("b2b_no_traffic", (n_rd - r0) + (n_wr - w0), 0);

    // Request withdrawn mid-miss: no ack, buffer left consistent
    we_i = 1'b0; rd_i = 1'b1; addr_i = 32'h4000;
    for (int c = 0; c < 40 && !line_rd_o; c++) step();
    chk("wd_fill_seen", {255'b0, line_rd_o}, 256'd1);
    rd_i = 1'b0;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ack_o) acks++;
    end
    chk("wd_no_ack", acks, 0);
    chk("wd_wb_addr", last_wr_addr, 32'h100);
    chk("wd_wb_word3", last_wr_line[3*32 +: 32], 32'h3);
    do_req(1'b0, 1'b1, 32'h4000, 32'h0, lat, rdata);
    chk("wd_hit_lat",  lat, 1);
    chk("wd_hit_data", rdata, 32'hA5A5_3F00);
    do_req(1'b0, 1'b1, 32'h11C, 32'h0, lat, rdata);
    chk("wd_clean_lat",  lat, 5);
    chk("wd_clean_data", rdata, 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_word_bridge.md
Name: ddr3_word_bridge

Overview:
- Responder on the 32-bit word bus (addr_i/data_i/data_o/we_i/rd_i/ack_o) that the CPU side uses to reach DDR3.
- Initiator on the 256-bit line interface of ddr3_ctrl.
- Holds one 256-bit line buffer, operated as a write-back, write-allocate single-line cache.
- Sits between the system bus and ddr3_ctrl.

Parameters:
- LINE_W, 256, line width in bits; must equal the ddr3_ctrl data width.
- WORD_W, 32, upstream word width.
- OFFS_W, 5, log2 of line size in bytes; fixed relation LINE_W = 8 << OFFS_W.

Ports:
- clk  in  1  system clock; same domain as ddr3_ctrl clk.
- rst  in  1  synchronous, active-high reset.
- addr_i  in  32  upstream byte address; bits [1:0] ignored.
- data_i  in  32  upstream write data.
- data_o  out  32  upstream read data; valid in the ack_o cycle, held until the next read ack.
- we_i  in  1  upstream write request; level, held until ack_o.
- rd_i  in  1  upstream read request; level, held until ack_o.
- ack_o  out  1  one-cycle completion pulse.
- line_addr_o  out  32  downstream line byte address, low OFFS_W bits zero.
- line_data_o  out  256  downstream write line.
- line_data_i  in  256  downstream read line; sampled on line_ack_i.
- line_we_o  out  1  downstream write request; held until line_ack_i.
- line_rd_o  out  1  downstream read request; held until line_ack_i.
- line_ack_i  in  1  downstream one-cycle completion pulse.

Behaviour:
- Buffer state:
  - valid, dirty flags.
  - tag = addr[31:OFFS_W].
  - 256-bit line.
  - Word index = addr[OFFS_W-1:2]; word k occupies line bits [32k+31:32k].
- Reset (synchronous, any state):
  - valid = 0, dirty = 0, state = IDLE.
  - ack_o = 0, line_we_o = 0, line_rd_o = 0, data_o = 0, line_addr_o = 0.
  - A downstream request in flight is dropped; dirty data is lost.
- Request selection: we_i has priority when both we_i and rd_i are high (treated as a write).
- FSM states: IDLE, WB, FILL, RESP.
- IDLE, request present, hit (valid and tag match):
  - Read: data_o <= selected word; ack_o pulses the next cycle (latency 1).
  - Write: selected word updated, dirty <= 1; ack_o pulses the next cycle.
  - Stays in IDLE.
- IDLE, miss, not (valid and dirty): go to FILL with line_addr_o = {addr_i[31:OFFS_W], 0}.
- IDLE, miss, valid and dirty: go to WB with line_addr_o = {old tag, 0} and line_data_o = buffer.
- WB:
  - line_we_o held high.
  - On line_ack_i: dirty <= 0, load line_addr_o with the requested line, go to FILL.
- FILL:
  - line_rd_o held high.
  - On line_ack_i: buffer <= line_data_i, tag <= requested tag, valid <= 1, go to RESP.
- RESP: services the pending request as a hit, i.e. write-merge or read-select; ack_o is asserted in this cycle; return to IDLE.
- Ack rules:
  - ack_o is never high two consecutive cycles for the same request.
  - The cycle after ack_o is IDLE and accepts a new request immediately; a back-to-back write then read to the same line produces a hit.
- Latency:
  - Hit: 1 cycle.
  - Clean miss: fill latency + 2.
  - Dirty miss: writeback latency + fill latency + 3.
- Downstream requests:
  - line_we_o and line_rd_o are never high simultaneously.
  - Each drops in the cycle after line_ack_i.
  - line_data_o and line_addr_o are stable while a request is high.
- Upstream request withdrawn mid-miss (protocol violation):
  - The downstream transaction completes and the buffer stays consistent.
  - RESP returns to IDLE without ack_o and without modifying the buffer.
- Address and request inputs are latched on leaving IDLE. Changes during WB or FILL are ignored.
- line_ack_i arriving in IDLE or RESP is ignored.

Decomposition:
- Shared package ddr3_pkg: LINE_W, WORD_W, OFFS_W, the FSM state encoding, and word-index/tag slicing helpers.
- The same package is used by ddr3_ctrl and test harnesses.
- One natural sub-module: ddr3_line_buf, holding the line, tag, valid and dirty, with a word-select read port and a word-merge write port.
- The FSM stays in ddr3_word_bridge.

Test Plan:
- Reset, then rd_i at 0x100 → line_rd_o high with line_addr_o = 0x100. Model acks with line word 0 = 0xA5A5_0000; ack_o pulses at fill + 2 with data_o = 0xA5A5_0000.
- Write 0x1234_5678 at 0x104 after that fill → ack_o 1 cycle later, no downstream activity. Reading 0x104 returns 0x1234_5678 in 1 cycle.
- Dirty miss: write 0x104, then read 0x2000 → line_we_o first with line_addr_o = 0x100 and word 1 of line_data_o = 0x1234_5678. After ack, line_rd_o with line_addr_o = 0x2000, then ack_o.
- we_i and rd_i both high at 0x108, data_i = 0xDEAD_BEEF → treated as a write. A subsequent read of 0x108 returns 0xDEAD_BEEF.
- rst asserted during FILL → next cycle line_rd_o = 0 and ack_o = 0. A read of the previously hit address misses and issues line_rd_o again.
- Back-to-back write/read pattern from the bring-up harness with the counter value as data, 8 iterations → every read returns the value just written, and exactly one ack_o per request.
